// File: rtl/ebc_event_decoder_pkg.sv
// Shared EBC arbiter package: packed event word geometry,
// field positions, polarity encodings and the word unpacker.
package ebc_event_decoder_pkg;

    localparam int SIZE     = 32;
    localparam int Lvl_ADD  = 1;
    localparam int Lvl0_ADD = 2;
    localparam int ROW_ADD  = Lvl_ADD + Lvl0_ADD;
    localparam int COL_ADD  = 3;
    localparam int POLARITY = 2;
    localparam int WIDTH    = SIZE + ROW_ADD + COL_ADD + 1;

    localparam int TS_LSB  = 7;
    localparam int ROW_LSB = 4;
    localparam int COL_LSB = 1;
    localparam int POL_BIT = 0;

    localparam logic [POLARITY-1:0] POL_ON  = 2'b10;
    localparam logic [POLARITY-1:0] POL_OFF = 2'b01;

    typedef struct packed {
        logic [SIZE-1:0]     ts;
        logic [ROW_ADD-1:0]  row;
        logic [COL_ADD-1:0]  col;
        logic [POLARITY-1:0] pol;
    } evt_t;

    function automatic evt_t unpack_evt(input logic [WIDTH-1:0] w);
        evt_t e;
        e.ts  = w[TS_LSB +: SIZE];
        e.row = w[ROW_LSB +: ROW_ADD];
        e.col = w[COL_LSB +: COL_ADD];
        e.pol = w[POL_BIT] ? POL_ON : POL_OFF;
        return e;
    endfunction

endpackage

// File: rtl/ebc_sync_fifo.sv
// Single-clock FIFO with occupancy count and combinational head.
// Pushes into a full FIFO and pops from an empty one are ignored.
module ebc_sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset, occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ebc_event_decoder.sv
// Receive-side EBC event decoder: FIFO, output register, field
// unpack, timestamp monotonicity check and per-polarity counters.
module ebc_event_decoder
    import ebc_event_decoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [WIDTH-1:0]    evt_data_i,
    input  logic                evt_valid_i,
    output logic                evt_ready_o,
    output logic [SIZE-1:0]     ts_o,
    output logic [ROW_ADD-1:0]  row_o,
    output logic [COL_ADD-1:0]  col_o,
    output logic [POLARITY-1:0] pol_o,
    output logic                ts_err_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    input  logic                clear_i,
    output logic [CNT_W-1:0]    on_cnt_o,
    output logic [CNT_W-1:0]    off_cnt_o,
    output logic                err_sticky_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             load;
    logic             deliver;
    logic             have_prev;
    logic [SIZE-1:0]  prev_ts;
    evt_t             dec;

    assign evt_ready_o = !fifo_full;
    assign load        = !fifo_empty && (!out_valid_o || out_ready_i);
    assign deliver     = out_valid_o && out_ready_i;
    assign dec         = unpack_evt(head);

    ebc_sync_fifo #(
        .DATA_W (WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (reset_i),
        .push    (evt_valid_i),
        .pop     (load),
        .wr_data (evt_data_i),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output register: load decoded head, else hold or drain on delivery.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_valid_o <= 1'b0;
            ts_o        <= '0;
            row_o       <= '0;
            col_o       <= '0;
            pol_o       <= '0;
            ts_err_o    <= 1'b0;
        end else if (load) begin
            out_valid_o <= 1'b1;
            ts_o        <= dec.ts;
            row_o       <= dec.row;
            col_o       <= dec.col;
            pol_o       <= dec.pol;
            ts_err_o    <= have_prev && (dec.ts < prev_ts);
        end else if (deliver) begin
            out_valid_o <= 1'b0;
        end
    end

    // Timestamp history of the last loaded event; clear forgets it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            have_prev <= 1'b0;
            prev_ts   <= '0;
        end else if (clear_i) begin
            have_prev <= 1'b0;
            prev_ts   <= '0;
        end else if (load) begin
            have_prev <= 1'b1;
            prev_ts   <= dec.ts;
        end
    end

    // Saturating delivery counters and sticky error; clear wins.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            on_cnt_o     <= '0;
            off_cnt_o    <= '0;
            err_sticky_o <= 1'b0;
        end else if (clear_i) begin
            on_cnt_o     <= '0;
            off_cnt_o    <= '0;
            err_sticky_o <= 1'b0;
        end else if (deliver) begin
            if (pol_o == POL_ON) begin
                if (on_cnt_o != CNT_MAX) begin
                    on_cnt_o <= on_cnt_o + CNT_W'(1);
                end
            end else begin
                if (off_cnt_o != CNT_MAX) begin
                    off_cnt_o <= off_cnt_o + CNT_W'(1);
                end
            end
            if (ts_err_o) begin
                err_sticky_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ebc_event_decoder.sv
// Self-checking bench for ebc_event_decoder: vector table plus
// hand sequences, with a scoreboard of expected delivered events.
module tb_ebc_event_decoder;
    import ebc_event_decoder_pkg::*;

    typedef struct packed {
        logic [31:0] ts;
        logic [2:0]  row;
        logic [2:0]  col;
        logic [1:0]  pol;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] ts;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        pol_bit;
        logic [1:0]  exp_pol;
        logic        exp_err;
    } vec_t;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] evt_data;
    logic             evt_valid;
    logic             evt_ready;
    logic [31:0]      ts_o;
    logic [2:0]       row_o;
    logic [2:0]       col_o;
    logic [1:0]       pol_o;
    logic             ts_err;
    logic             out_valid;
    logic             out_ready;
    logic             clear;
    logic [15:0]      on_cnt;
    logic [15:0]      off_cnt;
    logic             sticky;

    int   tests;
    int   failed;
    int   stalls;
    int   deliv_cnt;
    logic sb_en;
    exp_t cur_exp;
    exp_t sb_q[$];
    vec_t vecs[8];

    ebc_event_decoder #(
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .evt_data_i   (evt_data),
        .evt_valid_i  (evt_valid),
        .evt_ready_o  (evt_ready),
        .ts_o         (ts_o),
        .row_o        (row_o),
        .col_o        (col_o),
        .pol_o        (pol_o),
        .ts_err_o     (ts_err),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .clear_i      (clear),
        .on_cnt_o     (on_cnt),
        .off_cnt_o    (off_cnt),
        .err_sticky_o (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: record accepted words, compare delivered events.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (!reset && sb_en) begin
            if (evt_valid && evt_ready) begin
                sb_q.push_back(cur_exp);
            end
            if (out_valid && out_ready) begin
                deliv_cnt++;
                tests++;
                got = {ts_o, row_o, col_o, pol_o, ts_err};
                if (sb_q.size() == 0) begin
                    failed++;
                    $display("FAIL sb_unexpected: got %h, required no event", got);
                end else begin
                    e = sb_q.pop_front();
                    if (got !== e) begin
                        failed++;
                        $display("FAIL sb_event: got %h, required %h", got, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] ts, input logic [2:0] row,
                             input logic [2:0] col, input logic pol,
                             input logic [1:0] exp_pol, input logic err);
        logic acc;
        acc       = 1'b0;
        evt_data  = {ts, row, col, pol};
        cur_exp   = {ts, row, col, exp_pol, err};
        evt_valid = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = evt_ready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
        end
        evt_valid = 1'b0;
        if (!acc) begin
            tests++;
            failed++;
            $display("FAIL push_timeout: got ready=0, required ready=1");
        end
    endtask

    task automatic wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk);
            #1;
            done = (sb_q.size() == 0) && !out_valid;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic sat_burst(input int target);
        int  acc;
        int  n;
        logic a;
        acc = 0;
        n   = 0;
        evt_valid = 1'b1;
        while (acc < target && n < target + 1000) begin
            evt_data = {acc[31:0], 3'd1, 3'd2, 1'b0};
            @(negedge clk);
            a = evt_ready;
            @(posedge clk);
            #1;
            if (a) acc++;
            n++;
        end
        evt_valid = 1'b0;
        check("sat_accepted", acc, target);
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        int   exp_on;
        int   exp_off;
        int   acc;
        int   post;
        logic a;

        vecs[0] = '{32'd100,        3'd1, 3'd2, 1'b1, 2'b10, 1'b0};
        vecs[1] = '{32'd100,        3'd2, 3'd7, 1'b0, 2'b01, 1'b0};
        vecs[2] = '{32'd50,         3'd7, 3'd0, 1'b1, 2'b10, 1'b1};
        vecs[3] = '{32'd200,        3'd0, 3'd3, 1'b0, 2'b01, 1'b0};
        vecs[4] = '{32'hFFFF_FFF0,  3'd5, 3'd5, 1'b1, 2'b10, 1'b0};
        vecs[5] = '{32'hFFFF_FFF0,  3'd6, 3'd1, 1'b0, 2'b01, 1'b0};
        vecs[6] = '{32'd0,          3'd4, 3'd6, 1'b1, 2'b10, 1'b1};
        vecs[7] = '{32'd1,          3'd3, 3'd4, 1'b0, 2'b01, 1'b0};

        tests     = 0;
        failed    = 0;
        stalls    = 0;
        deliv_cnt = 0;
        sb_en     = 1'b1;
        cur_exp   = '0;
        reset     = 1'b1;
        evt_data  = '0;
        evt_valid = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, evt_ready}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ts", ts_o, 32'd0);
        check("rst_fields", {24'd0, row_o, col_o, pol_o}, 32'd0);
        check("rst_err", {30'd0, ts_err, sticky}, 32'd0);
        check("rst_cnts", {on_cnt, off_cnt}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single event: latency and field decode.
        push_word(32'h10, 3'd3, 3'd5, 1'b1, 2'b10, 1'b0);
        check("lat_k", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_k1", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        check("hold_ts", ts_o, 32'h10);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("single_on", on_cnt, 32'd1);
        check("single_gone", {31'd0, out_valid}, 32'd0);

        // Vector table at full rate, including timestamp regressions.
        pulse_clear();
        stalls  = 0;
        exp_on  = 0;
        exp_off = 0;
        for (int i = 0; i < 8; i++) begin
            push_word(vecs[i].ts, vecs[i].row, vecs[i].col,
                      vecs[i].pol_bit, vecs[i].exp_pol, vecs[i].exp_err);
            if (vecs[i].exp_pol == 2'b10) exp_on++;
            else exp_off++;
        end
        check("tbl_stalls", stalls, 32'd0);
        wait_drain("tbl_drain");
        check("tbl_sticky", {31'd0, sticky}, 32'd1);
        check("tbl_on", on_cnt, exp_on);
        check("tbl_off", off_cnt, exp_off);
        pulse_clear();
        check("clr_sticky", {31'd0, sticky}, 32'd0);
        check("clr_cnts", {on_cnt, off_cnt}, 32'd0);
        push_word(32'd10, 3'd2, 3'd1, 1'b1, 2'b10, 1'b0);
        wait_drain("post_clr_drain");
        check("post_clr_on", on_cnt, 32'd1);
        check("post_clr_sticky", {31'd0, sticky}, 32'd0);

        // Backpressure: FIFO_DEPTH + 1 words absorbed.
        out_ready = 1'b0;
        acc = 0;
        evt_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            evt_data = {32'd1000 + acc[31:0], acc[2:0], ~acc[2:0], acc[0]};
            cur_exp  = {32'd1000 + acc[31:0], acc[2:0], ~acc[2:0],
                        (acc[0] ? 2'b10 : 2'b01), 1'b0};
            @(negedge clk);
            a = evt_ready;
            @(posedge clk);
            #1;
            if (a) acc++;
        end
        evt_valid = 1'b0;
        check("bp_accepted", acc, 32'd5);
        check("bp_ready_low", {31'd0, evt_ready}, 32'd0);
        check("bp_sb_depth", sb_q.size(), 32'd5);
        out_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_on", on_cnt, 32'd3);

        // Clear on the same cycle as an ON delivery.
        out_ready = 1'b0;
        push_word(32'd2000, 3'd6, 3'd6, 1'b1, 2'b10, 1'b0);
        for (int n = 0; n < 20 && !out_valid; n++) begin
            @(posedge clk);
            #1;
        end
        check("cvd_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        clear     = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("cvd_on", on_cnt, 32'd0);
        check("cvd_delivered", {31'd0, out_valid}, 32'd0);

        // Saturation of the OFF counter.
        pulse_clear();
        sb_en = 1'b0;
        sat_burst(65535);
        check("sat_off_max", off_cnt, 32'hFFFF);
        sat_burst(5);
        check("sat_off_stick", off_cnt, 32'hFFFF);
        check("sat_on_zero", on_cnt, 32'd0);
        sb_en = 1'b1;

        // Async reset with three events buffered.
        out_ready = 1'b0;
        push_word(32'd5000, 3'd1, 3'd1, 1'b1, 2'b10, 1'b0);
        push_word(32'd5001, 3'd2, 3'd2, 1'b0, 2'b01, 1'b0);
        push_word(32'd5002, 3'd3, 3'd3, 1'b1, 2'b10, 1'b0);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_ready", {31'd0, evt_ready}, 32'd1);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        post = deliv_cnt;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("arst_no_emit", deliv_cnt - post, 32'd0);
        check("arst_idle", {31'd0, out_valid}, 32'd0);
        check("arst_cnts", {on_cnt, off_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
